// File: rtl/uart8_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled bit-centre sampling,
// valid/ready output buffer with framing and overrun error pulses.
`timescale 1ns/1ps

module uart8_receiver #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       err_frame,
  output logic       err_overrun
);

  localparam int DIV    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W = $clog2(DIV);
  localparam int SCNT_W = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_m, rx_s;
  logic [TICK_W-1:0] tcnt;
  logic              tick;

  state_t            state, state_d;
  logic [SCNT_W-1:0] scnt, scnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shreg, shreg_d;
  logic              rearm, rearm_d;
  logic              stop_done;

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rx_s take the old rx_m, giving two real flop stages.
      rx_m <= in;
      rx_s <= rx_m;
    end
  end

  assign tick = en && (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tcnt <= '0;
    else if (!en)  tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rearm   <= 1'b0;
    end else begin
      state   <= state_d;
      scnt    <= scnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      rearm   <= rearm_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d   = state;
    scnt_d    = scnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    rearm_d   = rearm;
    stop_done = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      scnt_d    = '0;
      bit_idx_d = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          // After a framing error, wait for the line to return high before hunting again.
          if (rearm) begin
            if (rx_s) rearm_d = 1'b0;
          end else if (!rx_s) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt == SCNT_MID) begin
            scnt_d    = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            scnt_d = scnt + 1'b1;
          end
        end
        DATA: begin
          if (scnt == SCNT_LAST) begin
            shreg_d[bit_idx] = rx_s;
            scnt_d           = '0;
            bit_idx_d        = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_d = STOP;
          end else begin
            scnt_d = scnt + 1'b1;
          end
        end
        STOP: begin
          if (scnt == SCNT_LAST) begin
            stop_done = 1'b1;
            scnt_d    = '0;
            state_d   = IDLE;
            if (!rx_s) rearm_d = 1'b1;
          end else begin
            scnt_d = scnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic deliver, frame_bad, accept;
  assign deliver   = stop_done && rx_s;
  assign frame_bad = stop_done && !rx_s;
  assign accept    = valid && ready;

  // A delivery that coincides with acceptance refills the buffer instead of overrunning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out         <= 8'h00;
      valid       <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= frame_bad;
      err_overrun <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          out   <= shreg;
          valid <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
